instruction_sequencer: RTL and testbench

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

---
 rtl/instruction_sequencer_if.sv | 33 +++
 rtl/instruction_sequencer.sv | 157 +++++++++++++++
 tb/tb_instruction_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_sequencer_if.sv
// Bus bundle between the instruction sequencer and its environment
// (instruction memory, RAM handshake, datapath controls and status flags).
interface instruction_sequencer_if #(
   parameter int PC_WIDTH = 6
);
   logic                start;
   logic [3:0]          instruction;
   logic                mem_ready;
   logic [PC_WIDTH-1:0] pc;
   logic                ir_load;
   logic                write_enable_RB;
   logic                read_ram;
   logic                write_ram;
   logic [3:0]          alu_opcode;
   logic                demultiplexor;
   logic                busy;
   logic                halted;
   logic                fault;
   logic [7:0]          retired;

   // The sequencer drives the datapath controls and consumes program/RAM inputs.
   modport master (
      input  start, instruction, mem_ready,
      output pc, ir_load, write_enable_RB, read_ram, write_ram,
             alu_opcode, demultiplexor, busy, halted, fault, retired
   );

   modport slave (
      output start, instruction, mem_ready,
      input  pc, ir_load, write_enable_RB, read_ram, write_ram,
             alu_opcode, demultiplexor, busy, halted, fault, retired
   );
endinterface

// File: rtl/instruction_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/writeback
// control FSM with RAM wait timeout, program counter and retired counter.
module instruction_sequencer #(
   parameter int PC_WIDTH    = 6,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                      clk,
   input  logic                      rst_n,
   instruction_sequencer_if.master   bus
);

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALTED, FAULT
   } state_t;

   localparam int         WAIT_W  = $clog2(MEM_TIMEOUT + 1);
   localparam logic [3:0] OP_SW   = 4'b0110;
   localparam logic [3:0] OP_LW   = 4'b0111;
   localparam logic [3:0] OP_HALT = 4'b1111;

   state_t              state, state_next;
   logic [3:0]          ir;
   logic [PC_WIDTH-1:0] pc_q;
   logic [7:0]          retired_q;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                retire;
   logic                pc_clear;

   logic       ir_load, write_enable_rb, read_ram, write_ram;
   logic       demultiplexor, busy, halted, fault;
   logic [3:0] alu_opcode;

   // NOTE: every variable written here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      retire     = 1'b0;
      pc_clear   = 1'b0;
      case (state)
         IDLE:      if (bus.start) state_next = FETCH;
         FETCH:     state_next = DECODE;
         DECODE: begin
            if (ir <= 4'd5)                     state_next = EXECUTE;
            else if (ir == OP_SW || ir == OP_LW) state_next = MEM;
            else if (ir == OP_HALT)             state_next = HALTED;
            else                                state_next = FAULT;
         end
         EXECUTE:   state_next = WRITEBACK;
         MEM: begin
            if (bus.mem_ready) begin
               if (ir == OP_SW) begin
                  state_next = FETCH;
                  retire     = 1'b1;
               end else begin
                  state_next = WRITEBACK;
               end
            end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
               state_next = FAULT;
            end
         end
         WRITEBACK: begin
            state_next = FETCH;
            retire     = 1'b1;
         end
         HALTED: begin
            if (bus.start) begin
               state_next = FETCH;
               pc_clear   = 1'b1;
            end
         end
         FAULT:     state_next = FAULT;
         default:   state_next = IDLE;
      endcase
   end

   // NOTE: reset is asynchronous, so all Moore outputs drop to zero the moment
   // rst_n falls, without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ir        <= 4'd0;
         pc_q      <= '0;
         retired_q <= 8'd0;
         wait_cnt  <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register update ordered
         // against the same pre-edge values.
         state <= state_next;
         if (state == FETCH) ir <= bus.instruction;
         // Counter only runs while waiting in MEM; any other state holds it clear.
         if (state == MEM) wait_cnt <= wait_cnt + WAIT_W'(1);
         else              wait_cnt <= '0;
         if (pc_clear)    pc_q <= '0;
         else if (retire) pc_q <= pc_q + PC_WIDTH'(1);
         if (retire && retired_q != 8'hFF) retired_q <= retired_q + 8'd1;
      end
   end

   always_comb begin
      ir_load         = 1'b0;
      write_enable_rb = 1'b0;
      read_ram        = 1'b0;
      write_ram       = 1'b0;
      demultiplexor   = 1'b0;
      busy            = 1'b0;
      halted          = 1'b0;
      fault           = 1'b0;
      alu_opcode      = 4'b0000;
      case (state)
         FETCH: begin
            ir_load = 1'b1;
            busy    = 1'b1;
         end
         DECODE:    busy = 1'b1;
         EXECUTE:   busy = 1'b1;
         MEM: begin
            busy          = 1'b1;
            demultiplexor = 1'b1;
            write_ram     = (ir == OP_SW);
            read_ram      = (ir == OP_LW);
         end
         WRITEBACK: begin
            busy            = 1'b1;
            write_enable_rb = 1'b1;
            demultiplexor   = (ir == OP_LW);
         end
         HALTED:    halted = 1'b1;
         FAULT:     fault  = 1'b1;
         default:   busy   = 1'b0;
      endcase
      // A writeback after LW carries opcode 0111, which maps to the idle ALU code.
      if (state == EXECUTE || state == WRITEBACK) begin
         case (ir)
            4'b0000: alu_opcode = 4'b0000;
            4'b0001: alu_opcode = 4'b0001;
            4'b0010: alu_opcode = 4'b0010;
            4'b0011: alu_opcode = 4'b0110;
            4'b0100: alu_opcode = 4'b0111;
            4'b0101: alu_opcode = 4'b1100;
            default: alu_opcode = 4'b0000;
         endcase
      end
   end

   assign bus.pc              = pc_q;
   assign bus.retired         = retired_q;
   assign bus.ir_load         = ir_load;
   assign bus.write_enable_RB = write_enable_rb;
   assign bus.read_ram        = read_ram;
   assign bus.write_ram       = write_ram;
   assign bus.alu_opcode      = alu_opcode;
   assign bus.demultiplexor   = demultiplexor;
   assign bus.busy            = busy;
   assign bus.halted          = halted;
   assign bus.fault           = fault;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed self-checking bench for instruction_sequencer: program memory model,
// scoreboard of expected writeback/retire results, reset and fault scenarios.
module tb_instruction_sequencer;

   localparam int PC_WIDTH    = 6;
   localparam int MEM_TIMEOUT = 15;

   typedef struct packed {
      logic [3:0]          alu;
      logic                demux;
      logic [PC_WIDTH-1:0] pc_next;
      logic [7:0]          ret_next;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   instruction_sequencer_if #(.PC_WIDTH(PC_WIDTH)) bus ();

   instruction_sequencer #(
      .PC_WIDTH    (PC_WIDTH),
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   logic [3:0]          prog [64];
   logic [PC_WIDTH-1:0] m_pc;
   logic [7:0]          m_ret;
   exp_t                sb [$];
   int                  n_checks = 0;
   int                  n_errors = 0;

   assign bus.instruction = prog[bus.pc];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] alu_map(input logic [3:0] op);
      case (op)
         4'b0000: return 4'b0000;
         4'b0001: return 4'b0001;
         4'b0010: return 4'b0010;
         4'b0011: return 4'b0110;
         4'b0100: return 4'b0111;
         4'b0101: return 4'b1100;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] all_outputs();
      return {6'd0, bus.pc, bus.ir_load, bus.write_enable_RB, bus.read_ram, bus.write_ram,
              bus.alu_opcode, bus.demultiplexor, bus.busy, bus.halted, bus.fault, bus.retired};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 with the DUT idle.
   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      check("reset_outputs_zero", all_outputs(), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("reset_idle_not_busy", bus.busy, 1'b0);
      m_pc  = '0;
      m_ret = 8'd0;
      sb.delete();
   endtask

   task automatic kick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic pop_exp(output exp_t e);
      check("scoreboard_nonempty", sb.size() > 0, 1'b1);
      if (sb.size() > 0) e = sb.pop_front();
      else               e = '0;
   endtask

   // Entered and left in FETCH.
   task automatic exec_alu(input logic [3:0] op);
      exp_t e;
      prog[m_pc] = op;
      check("fetch_ir_load", bus.ir_load, 1'b1);
      check("fetch_pc", bus.pc, m_pc);
      sb.push_back('{alu: alu_map(op), demux: 1'b0, pc_next: m_pc + 6'd1,
                     ret_next: (m_ret == 8'hFF) ? 8'hFF : m_ret + 8'd1});
      tick();
      check("decode_ir_load_low", bus.ir_load, 1'b0);
      check("decode_alu_zero", bus.alu_opcode, 4'd0);
      tick();
      check("execute_alu", bus.alu_opcode, alu_map(op));
      check("execute_no_we", bus.write_enable_RB, 1'b0);
      tick();
      pop_exp(e);
      check("wb_we", bus.write_enable_RB, 1'b1);
      check("wb_alu", bus.alu_opcode, e.alu);
      check("wb_demux", bus.demultiplexor, e.demux);
      tick();
      check("retire_pc", bus.pc, e.pc_next);
      check("retire_count", bus.retired, e.ret_next);
      m_pc  = e.pc_next;
      m_ret = e.ret_next;
   endtask

   task automatic exec_lw(input int w);
      exp_t e;
      int   reads;
      prog[m_pc] = 4'b0111;
      check("lw_fetch_ir_load", bus.ir_load, 1'b1);
      sb.push_back('{alu: 4'd0, demux: 1'b1, pc_next: m_pc + 6'd1,
                     ret_next: (m_ret == 8'hFF) ? 8'hFF : m_ret + 8'd1});
      tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      reads = 0;
      for (int i = 0; i < w; i++) begin
         reads += int'(bus.read_ram);
         check("lw_mem_demux", bus.demultiplexor, 1'b1);
         check("lw_mem_no_write", bus.write_ram, 1'b0);
         if (i == w - 1) bus.mem_ready = 1'b1;
         tick();
         bus.mem_ready = 1'b0;
      end
      check("lw_read_cycles", reads, w);
      pop_exp(e);
      check("lw_wb_we", bus.write_enable_RB, 1'b1);
      check("lw_wb_read_low", bus.read_ram, 1'b0);
      check("lw_wb_demux", bus.demultiplexor, e.demux);
      check("lw_wb_alu", bus.alu_opcode, e.alu);
      tick();
      check("lw_wb_single_pulse", bus.write_enable_RB, 1'b0);
      check("lw_retire_pc", bus.pc, e.pc_next);
      check("lw_retire_count", bus.retired, e.ret_next);
      m_pc  = e.pc_next;
      m_ret = e.ret_next;
   endtask

   task automatic exec_halt();
      prog[m_pc] = 4'b1111;
      check("halt_fetch_ir_load", bus.ir_load, 1'b1);
      tick();
      tick();
      check("halted_flag", bus.halted, 1'b1);
      check("halted_not_busy", bus.busy, 1'b0);
      check("halted_pc", bus.pc, m_pc);
      check("halted_retired", bus.retired, m_ret);
      tick();
      check("halted_pc_held", bus.pc, m_pc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int writes;
      logic [3:0] op;
      for (int i = 0; i < 64; i++) prog[i] = 4'b1111;
      bus.start     = 1'b0;
      bus.mem_ready = 1'b0;
      m_pc  = '0;
      m_ret = 8'd0;
      #1;
      do_reset();

      // ADD then HALT; restart keeps retired, then SUB, NOR, LW, HALT.
      kick();
      exec_alu(4'b0010);
      exec_halt();
      kick();
      check("restart_pc_clear", bus.pc, 6'd0);
      check("restart_keeps_retired", bus.retired, 8'd1);
      m_pc = '0;
      exec_alu(4'b0011);
      exec_alu(4'b0101);
      exec_lw(3);
      exec_halt();

      // Illegal opcode goes to FAULT straight after DECODE.
      do_reset();
      prog[0] = 4'b1010;
      kick();
      check("illegal_fetch", bus.ir_load, 1'b1);
      tick();
      check("illegal_decode_strobes", {bus.write_enable_RB, bus.read_ram, bus.write_ram}, 3'b000);
      tick();
      check("illegal_fault", bus.fault, 1'b1);
      check("illegal_no_strobes", {bus.write_enable_RB, bus.read_ram, bus.write_ram, bus.busy}, 4'b0000);

      // SW that never completes times out into FAULT; start is ignored there.
      do_reset();
      prog[0] = 4'b0110;
      kick();
      tick();
      tick();
      writes = 0;
      for (int i = 0; i < MEM_TIMEOUT; i++) begin
         writes += int'(bus.write_ram);
         tick();
      end
      check("sw_write_cycles", writes, MEM_TIMEOUT);
      check("sw_timeout_fault", bus.fault, 1'b1);
      check("sw_timeout_not_busy", bus.busy, 1'b0);
      check("sw_timeout_write_low", bus.write_ram, 1'b0);
      kick();
      tick();
      check("fault_ignores_start", {bus.fault, bus.busy, bus.ir_load}, 3'b100);
      check("fault_pc_held", bus.pc, 6'd0);

      // Reset asserted in the middle of a MEM wait.
      do_reset();
      prog[0] = 4'b0111;
      kick();
      tick();
      tick();
      check("midmem_read_high", bus.read_ram, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midmem_reset_outputs_zero", all_outputs(), 32'd0);
      @(negedge clk);
      bus.mem_ready = 1'b1;
      rst_n = 1'b1;
      tick();
      bus.mem_ready = 1'b0;
      check("post_reset_idle", {bus.busy, bus.read_ram, bus.pc}, 8'd0);
      m_pc  = '0;
      m_ret = 8'd0;
      sb.delete();

      // 300 ALU ops: pc wraps past 63 (AND at 63) and retired saturates.
      kick();
      for (int i = 0; i < 300; i++) begin
         if (m_pc == 6'd63) begin
            exec_alu(4'b0000);
            check("pc_wrap", bus.pc, 6'd0);
         end else begin
            op = 4'(i % 6);
            exec_alu(op);
         end
      end
      check("retired_saturated", bus.retired, 8'd255);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
